// File: rtl/mem_access_unit.sv
// Memory-stage data access controller: issues handshaked data-memory requests,
// stalls the pipeline until completion and returns aligned, extended load data.
module mem_access_unit #(
   parameter int N       = 32,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         MEM_MemRead_Input,
   input  logic         MEM_MemWrite_Input,
   input  logic [1:0]   MEM_MemSize_Input,
   input  logic         MEM_MemSigned_Input,
   input  logic [N-1:0] MEM_Address_Input,
   input  logic [N-1:0] MEM_WriteData_Input,
   output logic [N-1:0] MEM_ReadData_Output,
   output logic         MEM_Stall_Output,
   output logic         MEM_Misaligned_Output,
   output logic         MEM_BusError_Output,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [N-1:0] dmem_addr,
   output logic [3:0]   dmem_be,
   output logic [N-1:0] dmem_wdata,
   input  logic [N-1:0] dmem_rdata,
   input  logic         dmem_ready
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_req;
   logic            r_we;
   logic [N-1:0]    r_addr;
   logic [3:0]      r_be;
   logic [N-1:0]    r_wdata;
   logic [1:0]      r_size;
   logic            r_signed;
   logic [1:0]      r_lane;
   logic [N-1:0]    r_rdata;
   logic            r_misaligned;
   logic            r_buserr;
   logic [CW-1:0]   r_cnt;

   logic            w_access;
   logic            w_misaligned;
   logic            w_timeout;
   logic            w_stall;
   logic [3:0]      w_be;
   logic [N-1:0]    w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [N-1:0]    w_load_val;

   assign w_access     = MEM_MemRead_Input | MEM_MemWrite_Input;
   assign w_misaligned = w_access &
                         (((MEM_MemSize_Input == 2'b01) && MEM_Address_Input[0]) ||
                          (MEM_MemSize_Input[1] && (MEM_Address_Input[1:0] != 2'b00)));
   assign w_timeout    = (r_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = MEM_WriteData_Input;
      case (MEM_MemSize_Input)
         2'b00: begin
            w_be    = 4'b0001 << MEM_Address_Input[1:0];
            w_wdata = {4{MEM_WriteData_Input[7:0]}};
         end
         2'b01: begin
            w_be    = MEM_Address_Input[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{MEM_WriteData_Input[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the lane/size latched at request time, not the live inputs.
   assign w_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
   assign w_half = dmem_rdata[{r_lane[1], 4'b0000} +: 16];

   always_comb begin
      w_load_val = dmem_rdata;
      case (r_size)
         2'b00:   w_load_val = {{(N-8){r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load_val = {{(N-16){r_signed & w_half[15]}}, w_half};
         default: ;
      endcase
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               w_stall = 1'b1;
               w_next  = w_misaligned ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_stall = 1'b1;
            if (dmem_ready || w_timeout) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: stall is combinational from the inputs, so reset must mask it directly.
   assign MEM_Stall_Output = w_stall & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_be         <= '0;
         r_wdata      <= '0;
         r_size       <= '0;
         r_signed     <= 1'b0;
         r_lane       <= '0;
         r_rdata      <= '0;
         r_misaligned <= 1'b0;
         r_buserr     <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_next;
         r_misaligned <= 1'b0;
         r_buserr     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_access && !w_misaligned) begin
                  r_req    <= 1'b1;
                  r_we     <= MEM_MemWrite_Input;
                  r_addr   <= {MEM_Address_Input[N-1:2], 2'b00};
                  r_be     <= w_be;
                  r_wdata  <= w_wdata;
                  r_size   <= MEM_MemSize_Input;
                  r_signed <= MEM_MemSigned_Input;
                  r_lane   <= MEM_Address_Input[1:0];
                  r_cnt    <= '0;
               end else if (w_misaligned) begin
                  r_rdata      <= '0;
                  r_misaligned <= 1'b1;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + 1'b1;
               if (dmem_ready) begin
                  r_req   <= 1'b0;
                  r_rdata <= r_we ? '0 : w_load_val;
               end else if (w_timeout) begin
                  r_req    <= 1'b0;
                  r_rdata  <= '0;
                  r_buserr <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign MEM_ReadData_Output   = r_rdata;
   assign MEM_Misaligned_Output = r_misaligned;
   assign MEM_BusError_Output   = r_buserr;
   assign dmem_req              = r_req;
   assign dmem_we               = r_we;
   assign dmem_addr             = r_addr;
   assign dmem_be               = r_be;
   assign dmem_wdata            = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions compared against a byte-lane arithmetic reference model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr, sg;
   logic [1:0]  sz;
   logic [31:0] addr, wdat, rdata;
   logic        ready;
   logic        t_ready;

   logic [31:0] o_rd, daddr, bwdata;
   logic        stall, mis, berr, req, we;
   logic [3:0]  be;

   logic [31:0] t_rd, t_daddr, t_bwdata;
   logic        t_stall, t_mis, t_berr, t_req, t_we;
   logic [3:0]  t_be;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] model_rd = '0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .reset(reset),
      .MEM_MemRead_Input(rd), .MEM_MemWrite_Input(wr),
      .MEM_MemSize_Input(sz), .MEM_MemSigned_Input(sg),
      .MEM_Address_Input(addr), .MEM_WriteData_Input(wdat),
      .MEM_ReadData_Output(o_rd), .MEM_Stall_Output(stall),
      .MEM_Misaligned_Output(mis), .MEM_BusError_Output(berr),
      .dmem_req(req), .dmem_we(we), .dmem_addr(daddr), .dmem_be(be),
      .dmem_wdata(bwdata), .dmem_rdata(rdata), .dmem_ready(ready)
   );

   mem_access_unit #(.TIMEOUT(4)) dut_t4 (
      .clk(clk), .reset(reset),
      .MEM_MemRead_Input(rd), .MEM_MemWrite_Input(wr),
      .MEM_MemSize_Input(sz), .MEM_MemSigned_Input(sg),
      .MEM_Address_Input(addr), .MEM_WriteData_Input(wdat),
      .MEM_ReadData_Output(t_rd), .MEM_Stall_Output(t_stall),
      .MEM_Misaligned_Output(t_mis), .MEM_BusError_Output(t_berr),
      .dmem_req(t_req), .dmem_we(t_we), .dmem_addr(t_daddr), .dmem_be(t_be),
      .dmem_wdata(t_bwdata), .dmem_rdata(rdata), .dmem_ready(t_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_be(input int nb, input logic [31:0] a);
      return 4'(((1 << nb) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] ref_wdata(input int nb, input logic [31:0] wd);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] rdv, input logic [31:0] a,
                                            input int nb, input logic sgn);
      longint v;
      v = (longint'(rdv) >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 1);
      if (sgn && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
      return v[31:0];
   endfunction

   // One instruction through the MEM stage; delay = ready-low ACCESS cycles.
   task automatic run_txn(input logic rd_i, input logic wr_i, input logic [1:0] sz_i,
                          input logic sg_i, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int delay);
      int          nb, ncyc, acc;
      bit          done, misal;
      logic [31:0] exp_rd;
      nb    = (sz_i == 2'd0) ? 1 : (sz_i == 2'd1) ? 2 : 4;
      misal = (a % nb) != 0;
      exp_rd = (misal || wr_i) ? 32'd0 : ref_load(rdat, a, nb, sg_i);
      @(negedge clk);
      rd = rd_i; wr = wr_i; sz = sz_i; sg = sg_i; addr = a; wdat = wd;
      ready = 1'b0; rdata = $urandom;
      ncyc = 0; acc = 0; done = 0;
      while (!done && ncyc < 64) begin
         #1;
         if (!stall) done = 1;
         else begin
            ncyc++;
            check("rd_hold", o_rd, model_rd);
            check("req", {31'd0, req}, {31'd0, (ncyc >= 2) && !misal});
            check("flags_low", {30'd0, mis, berr}, 32'd0);
            if (req) begin
               acc++;
               check("bus_addr", daddr, {a[31:2], 2'b00});
               check("bus_be", {28'd0, be}, {28'd0, ref_be(nb, a)});
               check("bus_wdata", bwdata, ref_wdata(nb, wd));
               check("bus_we", {31'd0, we}, {31'd0, wr_i});
               ready = (acc == delay + 1);
               rdata = ready ? rdat : $urandom;
            end else begin
               ready = 1'($urandom);
               rdata = $urandom;
            end
            @(negedge clk);
         end
      end
      check("completed", {31'd0, done}, 32'd1);
      check("stall_cycles", ncyc, misal ? 1 : delay + 2);
      check("done_rdata", o_rd, exp_rd);
      check("done_misaligned", {31'd0, mis}, {31'd0, misal});
      check("done_buserr", {31'd0, berr}, 32'd0);
      check("done_req", {31'd0, req}, 32'd0);
      model_rd = exp_rd;
      ready = 1'($urandom); rdata = $urandom;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; ready = 1'($urandom);
      #1;
      check("idle_stall", {31'd0, stall}, 32'd0);
      check("idle_flags", {29'd0, mis, berr, req}, 32'd0);
      check("idle_rd_hold", o_rd, model_rd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ncyc;
      bit          done;
      logic [1:0]  rsz;
      logic [31:0] ra;
      logic        rrd, rwr;

      reset = 1'b1; rd = 1'b1; wr = 1'b0; sz = 2'd2; sg = 1'b0;
      addr = 32'h40; wdat = '0; rdata = '0; ready = 1'b0; t_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall_masked", {31'd0, stall}, 32'd0);
      check("reset_outputs", {28'd0, be} | daddr | bwdata | o_rd, 32'd0);
      check("reset_ctrl", {28'd0, req, we, mis, berr}, 32'd0);
      @(negedge clk);
      reset = 1'b0; rd = 1'b0;

      // Directed cases from the block's intended usage.
      run_txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80AABBCC, 0);
      check("lbu_value", o_rd, 32'h00000080);
      run_txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80AABBCC, 0);
      check("lb_value", o_rd, 32'hFFFFFF80);
      run_txn(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0, 0);
      run_txn(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h13579BDF, 5);
      check("lw_value", o_rd, 32'h13579BDF);
      run_txn(1, 0, 2'd1, 1, 32'h41, 32'h0, 32'hFFFFFFFF, 0);
      run_txn(1, 0, 2'd2, 0, 32'h42, 32'h0, 32'hFFFFFFFF, 0);
      run_txn(1, 1, 2'd3, 0, 32'h84, 32'hCAFEF00D, 32'h11111111, 1);
      run_txn(1, 0, 2'd1, 1, 32'h2E, 32'h0, 32'h8001_7FFF, 2);

      for (int i = 0; i < 60; i++) begin
         rsz = 2'($urandom_range(0, 3));
         ra  = $urandom;
         if ($urandom_range(0, 3) != 0)
            ra[1:0] = (rsz == 2'd0) ? ra[1:0] : (rsz == 2'd1) ? {ra[1], 1'b0} : 2'b00;
         rrd = 1'($urandom);
         rwr = rrd ? 1'($urandom) : 1'b1;
         run_txn(rrd, rwr, rsz, 1'($urandom), ra, $urandom, $urandom, $urandom_range(0, 6));
      end

      // Reset while a request is outstanding; a late ready must be ignored.
      run_txn(1, 0, 2'd2, 0, 32'h80, 32'h0, 32'hDEADBEEF, 0);
      @(negedge clk);
      rd = 1'b1; wr = 1'b0; sz = 2'd2; addr = 32'h84; ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("pre_reset_req", {31'd0, req}, 32'd1);
      reset = 1'b1;
      #1;
      check("reset_stall_forced", {31'd0, stall}, 32'd0);
      @(negedge clk);
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_bus", daddr | bwdata | {28'd0, be} | {31'd0, we}, 32'd0);
      check("rst_rdata", o_rd, 32'd0);
      reset = 1'b0; rd = 1'b0; ready = 1'b1; rdata = $urandom;
      @(negedge clk);
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("post_rst_quiet", {29'd0, req, stall, mis}, 32'd0);
         check("post_rst_rdata", o_rd, 32'd0);
         @(negedge clk);
      end

      // Timeout on the TIMEOUT=4 instance: ready never arrives.
      rd = 1'b1; wr = 1'b0; sz = 2'd2; addr = 32'h40; ready = 1'b0;
      ncyc = 0; done = 0;
      while (!done && ncyc < 20) begin
         #1;
         if (!t_stall) done = 1;
         else begin
            ncyc++;
            check("t4_req", {31'd0, t_req}, {31'd0, ncyc >= 2});
            check("t4_berr_early", {31'd0, t_berr}, 32'd0);
            @(negedge clk);
         end
      end
      check("t4_completed", {31'd0, done}, 32'd1);
      check("t4_stall_cycles", ncyc, 5);
      check("t4_buserr", {31'd0, t_berr}, 32'd1);
      check("t4_rdata", t_rd, 32'd0);
      check("t4_req_done", {30'd0, t_req, t_mis}, 32'd0);
      check("main_still_waiting", {31'd0, stall}, 32'd1);
      @(negedge clk);
      rd = 1'b0;
      #1;
      check("t4_buserr_pulse", {31'd0, t_berr}, 32'd0);
      check("t4_idle_stall", {31'd0, t_stall}, 32'd0);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
